// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a byte FIFO that a sequencer drains into one uart_tx.
// Define UART_TX_ARB_LOCK_EN to keep a requester's multi-byte message contiguous.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DEPTH   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_start,
   input  logic                       tx_busy,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
   localparam logic [IW:0]   C_NREQ = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0] C_LAST = IW'(NUM_REQ-1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t          r_state;
   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [AW:0]     r_count;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_grant;
   logic [7:0]      r_tx_data;
   logic            r_tx_start;
`ifdef UART_TX_ARB_LOCK_EN
   logic            r_locked;
   logic [IW-1:0]   r_lock_id;
`else
   logic            w_unused_last;
   assign w_unused_last = ^req_last;
`endif

   logic [IW:0]        w_sum;
   logic [IW-1:0]      w_idx;
   logic [IW-1:0]      w_sel;
   logic               w_hit;
   logic               w_allow;
   logic               w_full;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_push;
   logic               w_pop;

   assign w_full = (r_count == C_FULL);
   assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

   // Cyclic search for the first eligible valid requester starting at the pointer.
   always_comb begin
      w_hit   = 1'b0;
      w_sel   = '0;
      w_sum   = '0;
      w_idx   = '0;
      w_allow = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_sum >= C_NREQ) begin
            w_sum = w_sum - C_NREQ;
         end else begin
            w_sum = w_sum;
         end
         w_idx = w_sum[IW-1:0];
`ifdef UART_TX_ARB_LOCK_EN
         w_allow = !r_locked || (w_idx == r_lock_id);
`else
         w_allow = 1'b1;
`endif
         if (!w_hit && req_valid[w_idx] && w_allow) begin
            w_hit = 1'b1;
            w_sel = w_idx;
         end else begin
            w_hit = w_hit;
         end
      end
   end

   // Grant strobe: suppressed during reset and whenever the FIFO is full.
   always_comb begin
      w_ready = '0;
      if (!reset && !w_full && w_hit) begin
         w_ready[w_sel] = 1'b1;
      end else begin
         w_ready = '0;
      end
   end

   assign w_push    = |(req_valid & w_ready);
   assign req_ready = w_ready;

   // FIFO storage, written on every accepted byte.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= req_data[{w_sel, 3'b000} +: 8];
      end
   end

   // FIFO pointers, occupancy, arbitration pointer, grant and lock.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_count <= '0;
         r_ptr   <= '0;
         r_grant <= '0;
`ifdef UART_TX_ARB_LOCK_EN
         r_locked  <= 1'b0;
         r_lock_id <= '0;
`endif
      end else begin
         if (w_push) begin
            r_wr    <= r_wr + AW'(1);
            r_grant <= w_sel;
            r_ptr   <= (w_sel == C_LAST) ? '0 : w_sel + IW'(1);
`ifdef UART_TX_ARB_LOCK_EN
            r_locked  <= !req_last[w_sel];
            r_lock_id <= w_sel;
`endif
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sequencer: pop one byte, pulse start, then follow the serializer's busy handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_rd       <= '0;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_tx_data <= r_mem[r_rd];
                  r_rd      <= r_rd + AW'(1);
                  r_state   <= S_START;
               end
            end
            S_START: begin
               r_tx_start <= 1'b1;
               r_state    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (tx_busy) r_state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (!tx_busy) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign fifo_count = r_count;
   assign grant_id   = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a small uart_tx busy model.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [3:0]  fifo_count;
   logic [1:0]  grant_id;

   logic        model_busy;
   logic [2:0]  model_cnt;
   logic        hold_busy;
   logic [7:0]  sent_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .DEPTH(8)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .fifo_count(fifo_count),
      .grant_id(grant_id)
   );

   assign tx_busy = model_busy | hold_busy;

   // Serializer model: busy rises the cycle after tx_start and lasts 3 cycles.
   always @(posedge clk) begin
      if (reset) begin
         model_busy <= 1'b0;
         model_cnt  <= 3'd0;
      end else if (tx_start) begin
         model_busy <= 1'b1;
         model_cnt  <= 3'd3;
      end else if (model_cnt != 3'd0) begin
         model_cnt <= model_cnt - 3'd1;
         if (model_cnt == 3'd1) model_busy <= 1'b0;
      end
   end

   // Record every byte handed to the serializer.
   always @(posedge clk) begin
      if (reset) sent_q.delete();
      else if (tx_start) sent_q.push_back(tx_data);
   end

   task automatic do_reset();
      reset = 1'b1; req_valid = 4'h0; req_last = 4'h0; req_data = 32'h0; hold_busy = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 4'hF; req_last = 4'h0; req_data = 32'h0; hold_busy = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rst_ready: got %h exp 0", req_ready); end
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b exp 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", fifo_count); end
      n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rst_grant: got %0d exp 0", grant_id); end
      reset = 1'b0; #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_ptr: got %b exp 0001", req_ready); end
      req_valid = 4'h0;
      @(negedge clk);
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL rst_idle_count: got %0d exp 0", fifo_count); end
   endtask

   task automatic test_single();
      do_reset();
      req_data = 32'h0000_0055; req_valid = 4'b0001; #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b exp 0001", req_ready); end
      @(negedge clk); req_valid = 4'h0;
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL single_cnt1: got %0d exp 1", fifo_count); end
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_n1: got %b exp 0", tx_start); end
      @(negedge clk);
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL single_pop: got %0d exp 0", fifo_count); end
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_n2: got %b exp 0", tx_start); end
      @(negedge clk);
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b exp 1", tx_start); end
      n_cmp++; if (tx_data !== 8'h55) begin n_err++; $display("FAIL single_data: got %h exp 55", tx_data); end
      @(negedge clk);
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_pulse_len: got %b exp 0", tx_start); end
      repeat (20) @(negedge clk);
      n_cmp++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL single_pulses: got %0d exp 1", sent_q.size()); end
      n_cmp++; if (tx_data !== 8'h55) begin n_err++; $display("FAIL single_hold: got %h exp 55", tx_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_r;
      do_reset();
      req_data = 32'hA3A2_A1A0; req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         exp_r = 4'b0001 << (i % 4);
         #1;
         n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL rr_ready[%0d]: got %b exp %b", i, req_ready, exp_r); end
         @(negedge clk);
         n_cmp++; if (grant_id !== 2'(i % 4)) begin n_err++; $display("FAIL rr_grant[%0d]: got %0d exp %0d", i, grant_id, i % 4); end
      end
      req_valid = 4'h0;
      for (int c = 0; c < 200 && sent_q.size() < 8; c++) @(negedge clk);
      n_cmp++; if (sent_q.size() !== 8) begin n_err++; $display("FAIL rr_count: got %0d exp 8", sent_q.size()); end
      for (int i = 0; i < 8 && i < sent_q.size(); i++) begin
         n_cmp++; if (sent_q[i] !== 8'hA0 + 8'(i % 4)) begin n_err++; $display("FAIL rr_byte[%0d]: got %h exp %h", i, sent_q[i], 8'hA0 + 8'(i % 4)); end
      end
   endtask

   task automatic test_stall();
      int   k;
      logic rdy;
      do_reset();
      hold_busy = 1'b1; req_valid = 4'b0001; k = 0;
      for (int c = 0; c < 100 && fifo_count != 4'd8; c++) begin
         req_data[7:0] = 8'h10 + 8'(k); #1; rdy = req_ready[0];
         @(negedge clk); if (rdy) k++;
      end
      n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL stall_full: got %0d exp 8", fifo_count); end
      n_cmp++; if (k !== 9) begin n_err++; $display("FAIL stall_accepts: got %0d exp 9", k); end
      req_data[7:0] = 8'h10 + 8'(k);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b exp 0000", i, req_ready); end
         @(negedge clk);
         n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL stall_sat[%0d]: got %0d exp 8", i, fifo_count); end
      end
      hold_busy = 1'b0;
      for (int c = 0; c < 200 && k < 10; c++) begin
         req_data[7:0] = 8'h10 + 8'(k); #1; rdy = req_ready[0];
         @(negedge clk); if (rdy) k++;
         if (k == 10) req_valid = 4'h0;
      end
      req_valid = 4'h0;
      for (int c = 0; c < 400 && sent_q.size() < 10; c++) @(negedge clk);
      repeat (20) @(negedge clk);
      n_cmp++; if (sent_q.size() !== 10) begin n_err++; $display("FAIL stall_sent: got %0d exp 10", sent_q.size()); end
      for (int i = 0; i < 10 && i < sent_q.size(); i++) begin
         n_cmp++; if (sent_q[i] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL stall_byte[%0d]: got %h exp %h", i, sent_q[i], 8'h10 + 8'(i)); end
      end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL stall_drain: got %0d exp 0", fifo_count); end
   endtask

   task automatic test_lock();
      int         n1, acc;
      int         exp_g[4];
      logic [3:0] rdy;
`ifdef UART_TX_ARB_LOCK_EN
      exp_g = '{1, 1, 1, 2};
`else
      exp_g = '{1, 2, 1, 2};
`endif
      do_reset();
      req_data = 32'h0022_1100; req_valid = 4'b0110; n1 = 0; acc = 0;
      for (int c = 0; c < 60 && acc < 4; c++) begin
         req_data[15:8] = 8'h11 + 8'(n1);
         req_last[1]    = (n1 == 2);
         req_valid[1]   = (n1 < 3);
         #1; rdy = req_ready & req_valid;
         @(negedge clk);
         if (rdy != 4'h0) begin
            n_cmp++; if (grant_id !== 2'(exp_g[acc])) begin n_err++; $display("FAIL lock_grant[%0d]: got %0d exp %0d", acc, grant_id, exp_g[acc]); end
            if (rdy[1]) n1++;
            acc++;
         end
      end
      n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL lock_accepts: got %0d exp 4", acc); end
      req_valid = 4'h0; req_last = 4'h0;
   endtask

   task automatic test_reset_mid();
      int   k;
      logic rdy;
      do_reset();
      hold_busy = 1'b1; req_valid = 4'b0001; k = 0;
      for (int c = 0; c < 50 && k < 6; c++) begin
         req_data[7:0] = 8'h30 + 8'(k); #1; rdy = req_ready[0];
         @(negedge clk); if (rdy) k++;
         if (k == 6) req_valid = 4'h0;
      end
      req_valid = 4'h0;
      repeat (4) @(negedge clk);
      n_cmp++; if (fifo_count !== 4'd5) begin n_err++; $display("FAIL mid_queued: got %0d exp 5", fifo_count); end
      reset = 1'b1; hold_busy = 1'b0;
      @(negedge clk); reset = 1'b0;
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL mid_count: got %0d exp 0", fifo_count); end
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_start: got %b exp 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL mid_data: got %h exp 00", tx_data); end
      n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL mid_grant: got %0d exp 0", grant_id); end
      req_data = 32'h0077_0000; req_valid = 4'b0100; #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_ready: got %b exp 0100", req_ready); end
      @(negedge clk); req_valid = 4'h0;
      n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL mid_grant2: got %0d exp 2", grant_id); end
      for (int c = 0; c < 50 && sent_q.size() < 1; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      n_cmp++; if (sent_q.size() !== 1) begin n_err++; $display("FAIL mid_sent: got %0d exp 1", sent_q.size()); end
      if (sent_q.size() > 0) begin
         n_cmp++; if (sent_q[0] !== 8'h77) begin n_err++; $display("FAIL mid_byte: got %h exp 77", sent_q[0]); end
      end
   endtask

   task automatic test_push_pop();
      int   k;
      logic rdy;
      do_reset();
      hold_busy = 1'b1; req_valid = 4'b0001; k = 0;
      for (int c = 0; c < 50 && k < 5; c++) begin
         req_data[7:0] = 8'h40 + 8'(k); #1; rdy = req_ready[0];
         @(negedge clk); if (rdy) k++;
         if (k == 5) req_valid = 4'h0;
      end
      req_valid = 4'h0;
      repeat (6) @(negedge clk);
      n_cmp++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL pp_before: got %0d exp 4", fifo_count); end
      hold_busy = 1'b0;
      @(negedge clk);
      n_cmp++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL pp_idle: got %0d exp 4", fifo_count); end
      req_data[7:0] = 8'h45; req_valid = 4'b0001;
      @(negedge clk); req_valid = 4'h0;
      n_cmp++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL pp_same_cycle: got %0d exp 4", fifo_count); end
      n_cmp++; if (tx_data !== 8'h41) begin n_err++; $display("FAIL pp_pop_data: got %h exp 41", tx_data); end
      @(negedge clk);
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL pp_start: got %b exp 1", tx_start); end
      for (int c = 0; c < 200 && sent_q.size() < 6; c++) @(negedge clk);
      n_cmp++; if (sent_q.size() !== 6) begin n_err++; $display("FAIL pp_sent: got %0d exp 6", sent_q.size()); end
      for (int i = 0; i < 6 && i < sent_q.size(); i++) begin
         n_cmp++; if (sent_q[i] !== 8'h40 + 8'(i)) begin n_err++; $display("FAIL pp_byte[%0d]: got %h exp %h", i, sent_q[i], 8'h40 + 8'(i)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_lock();
      test_reset_mid();
      test_push_pop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` serializer among `NUM_REQ` byte-stream requesters, such as the CPU console, debug dump and trace. Requesters are served round-robin into a `DEPTH`-entry byte FIFO. A sequencer drains the FIFO into the serializer one byte at a time, pulsing `tx_start` and tracking `tx_busy`. The block sits between the SoC byte producers and the `uart_tx` instance, driving its `data_in`/`tx_start` and observing its `tx_busy`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `DEPTH`, 8, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester byte valid.
- `req_data`  in  8*NUM_REQ  requester i byte on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  last byte of a message; used only with lock enabled.
- `req_ready`  out  NUM_REQ  one-hot (or zero) accept strobe.
- `tx_data`  out  8  byte to `uart_tx.data_in`.
- `tx_start`  out  1  one-cycle start pulse to `uart_tx.tx_start`.
- `tx_busy`  in  1  from `uart_tx.tx_busy`.
- `fifo_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `grant_id`  out  $clog2(NUM_REQ)  index of the most recently accepted requester.

## Operation
- Reset values: `tx_start`=0, `tx_data`=0, `fifo_count`=0, `grant_id`=0. The round-robin pointer is 0, the FIFO is empty, the lock is clear, and the sequencer is IDLE.
- `req_ready` is forced to 0 while `reset` is high.
- Arbitration is combinational from registered state and `req_valid`:
  - When `fifo_count` < DEPTH, the first valid requester at or after the pointer (cyclic) gets `req_ready`=1.
  - Otherwise all `req_ready` are 0, even if a pop happens in the same cycle.
  - A transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1.
  - `req_valid` must not depend on `req_ready`.
- On transfer from requester i:
  - The byte is pushed to the FIFO.
  - `grant_id` is set to i.
  - The pointer is set to (i+1) mod NUM_REQ.
- FIFO behaviour:
  - Pointers wrap modulo DEPTH.
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - A pop never occurs when empty.
- Sequencer FSM:
  - IDLE: if the FIFO is non-empty, pop the head into `tx_data` and go to START.
  - START: `tx_start`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `tx_busy`=0, then go to IDLE.
  - `tx_data` is held stable from the IDLE pop until the next pop.
- Reset asserted mid-operation (any state, FIFO contents) discards everything and returns all state to reset values on the next edge. The serializer shares the same reset.

## Timing
- A byte accepted at edge N appears in the FIFO at N+1.
- If the sequencer is IDLE with an empty FIFO, the pop happens at edge N+1 and `tx_start` is high in the cycle after edge N+2.
- `tx_busy` from the serializer rises one cycle after `tx_start`, so WAIT_BUSY lasts ≥1 cycle.
- Back-to-back bytes: the next `tx_start` comes 3 cycles after `tx_busy` falls (WAIT_DONE→IDLE→START).
- The FIFO accepts at most one byte per cycle. Under sustained multi-requester load, each valid requester gets one byte per NUM_REQ accepts.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined (message lock):
  - After accepting a byte with `req_last`=0 from requester i, the lock is set to i.
  - While locked, only requester i can get `req_ready`; other requesters wait even if i deasserts valid.
  - Accepting a byte with `req_last`=1 from i clears the lock, and the pointer moves to i+1.
  - Reset clears the lock.
- Macro undefined: `req_last` is ignored, no lock state exists, and arbitration rotates after every byte.

## Test plan
- Single requester 0 sends 0x55 after reset with the FIFO empty -> `req_ready[0]`=1 in the same cycle; `tx_start` pulses once exactly 2 cycles after acceptance with `tx_data`=0x55; no second pulse until `tx_busy` has risen and fallen.
- Requesters 0..3 all hold valid with bytes 0xA0..0xA3, lock disabled -> accept order 0,1,2,3,0…; the `grant_id` sequence matches; the serializer output byte order matches the accept order.
- Stall the serializer (`tx_busy` held 1) while pushing DEPTH+2 bytes -> `fifo_count` saturates at 8; all `req_ready`=0 while full; no byte is lost or duplicated after `tx_busy` is released.
- With `UART_TX_ARB_LOCK_EN`, requester 1 sends a 3-byte message (last on the 3rd) while requester 2 is valid throughout -> bytes 1,1,1 are accepted, then requester 2's byte.
- Assert `reset` for 1 cycle while in WAIT_DONE with 5 bytes queued -> `fifo_count`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0; the next accepted byte is sent normally.
- Push and pop in the same cycle with 4 bytes queued -> `fifo_count` stays 4.
